// File: rtl/lp_buf.sv
// Line-printer byte buffer: 8-entry FIFO between DMA word reads and the printer.
// Optional odd-parity output is built only when LPBUF_PARITY_EN is defined.
module lp_buf (
   input  logic        clk,
   input  logic        rst,
   input  logic [35:0] lpDATAI,
   input  logic        lpLOAD,
   input  logic [1:0]  lpBYTESEL,
   input  logic        lpCLR,
   output logic        lpREADY,
   output logic        lpEMPTY,
   output logic        lpOVFL,
   output logic [7:0]  prDATA,
   output logic        prVALID,
   input  logic        prACK,
   output logic        prPAR
);

   localparam int unsigned DEPTH = 8;

   logic [2:0] wr_ptr_q, wr_ptr_d;
   logic [2:0] rd_ptr_q, rd_ptr_d;
   logic [3:0] count_q, count_d;
   logic       ovfl_q, ovfl_d;
   logic [7:0] mem_q [DEPTH];
   logic [7:0] mem_d [DEPTH];

   logic [7:0] byte_sel;
   logic       full;
   logic       pop;
   logic       push;
   logic       drop;
   logic       unused_bits;

   // Only four byte lanes of the 36-bit word carry characters.
   always_comb begin
      byte_sel = 8'h00;
      case (lpBYTESEL)
         2'd0:    byte_sel = lpDATAI[25:18];
         2'd1:    byte_sel = lpDATAI[33:26];
         2'd2:    byte_sel = lpDATAI[7:0];
         default: byte_sel = lpDATAI[15:8];
      endcase
   end

   assign unused_bits = ^{lpDATAI[35:34], lpDATAI[17:16]};

   assign full = (count_q == 4'd8);
   assign pop  = prVALID & prACK;
   // A pop in the same cycle frees the slot, so a full buffer still accepts.
   assign push = lpLOAD & (~full | pop);
   assign drop = lpLOAD & full & ~pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovfl_d   = ovfl_q;
      if (lpCLR) begin
         wr_ptr_d = 3'd0;
         rd_ptr_d = 3'd0;
         count_d  = 4'd0;
         ovfl_d   = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 3'd1;
         if (pop)  rd_ptr_d = rd_ptr_q + 3'd1;
         case ({push, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
         endcase
         if (drop) ovfl_d = 1'b1;
      end
   end

   always_comb begin
      mem_d = mem_q;
      if (push && !lpCLR) mem_d[wr_ptr_q] = byte_sel;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= 3'd0;
         rd_ptr_q <= 3'd0;
         count_q  <= 4'd0;
         ovfl_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovfl_q   <= ovfl_d;
      end
   end

   // Storage carries no reset; stale entries are unreachable once count is 0.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign lpREADY = (count_q < 4'd8);
   assign lpEMPTY = (count_q == 4'd0);
   assign prVALID = (count_q != 4'd0);
   assign prDATA  = mem_q[rd_ptr_q];
   assign lpOVFL  = ovfl_q;

`ifdef LPBUF_PARITY_EN
   assign prPAR = prVALID & ~^prDATA;
`else
   assign prPAR = 1'b0;
`endif

endmodule

// File: doc/lp_buf.md
LP_BUF -- requirements
Module: lp_buf

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  reset, asynchronous and active-high.
REQ-003 lpDATAI  input  36  word returned by bus read; valid only in the cycle lpLOAD is high.
REQ-004 lpLOAD  input  1  one-cycle strobe: capture one byte from lpDATAI (driven by the DMA increment pulse).
REQ-005 lpBYTESEL  input  2  byte address low bits for the byte being loaded.
REQ-006 lpCLR  input  1  synchronous flush (stop command / controller clear).
REQ-007 lpREADY  output  1  buffer can accept a byte; gates the DMA read request.
REQ-008 lpEMPTY  output  1  buffer holds no bytes.
REQ-009 lpOVFL  output  1  sticky overflow error.
REQ-010 prDATA  output  8  character at the buffer head.
REQ-011 prVALID  output  1  prDATA is valid.
REQ-012 prACK  input  1  printer consumed prDATA.
REQ-013 prPAR  output  1  odd parity of prDATA (see Configuration).

Function
REQ-014 Byte selection: lpBYTESEL 0 -> lpDATAI[25:18], 1 -> [33:26], 2 -> [7:0], 3 -> [15:8]; all other bits are ignored.
REQ-015 Storage: 8-entry circular FIFO; 3-bit write and read pointers wrap 7 -> 0; 4-bit count, range 0-8.
REQ-016 Push: lpLOAD with count<8 writes the selected byte at the write pointer, increments the pointer, and increments the count at that edge.
REQ-017 Pop: prVALID & prACK at an edge increments the read pointer and decrements the count.
REQ-018 Simultaneous push and pop: both pointers advance; count unchanged; holds at count 8 (push accepted) and at count 0 only if prVALID is high (never true, so no pop occurs).
REQ-019 Overflow: lpLOAD with count==8 and no pop in the same cycle drops the byte, leaves FIFO state unchanged, and sets lpOVFL on the next edge.
REQ-020 lpOVFL stays set until lpCLR or rst.
REQ-021 lpREADY = (count<8); combinational from registered count.
REQ-022 lpEMPTY = (count==0).
REQ-023 prVALID = (count!=0).
REQ-024 prDATA = entry at the read pointer.
REQ-025 Latency: a byte pushed into an empty FIFO at edge N produces prVALID high after edge N.
REQ-026 prDATA and prVALID are held stable while prACK is low.
REQ-027 prACK while prVALID is low is ignored.
REQ-028 lpCLR has priority over push and pop: pointers and count go to 0, lpOVFL clears, and storage contents are don't-care.
REQ-029 FIFO ordering: bytes exit in exactly push order across pointer wrap.

Reset
REQ-030 rst asynchronously forces pointers=0, count=0, and lpOVFL=0.
REQ-031 During reset, outputs are lpREADY=1, lpEMPTY=1, prVALID=0, lpOVFL=0, prPAR=0; prDATA is don't-care.
REQ-032 Reset mid-transfer discards buffered bytes; storage RAM needs no reset.

Configuration
REQ-033 Macro LPBUF_PARITY_EN: when defined, prPAR = ~^prDATA while prVALID is high, and 0 otherwise.
REQ-034 When LPBUF_PARITY_EN is undefined, prPAR is tied to 0 and no parity logic is synthesized.

Verification
REQ-035 Byte select: lpDATAI=36'o123456701234, lpBYTESEL=0..3 loaded in turn, prACK held high -> prDATA sequence equals bits[25:18], [33:26], [7:0], [15:8] of that word, in order.
REQ-036 Fill/overflow: prACK=0, push 9 bytes 0x01..0x09 -> lpREADY low after the 8th push, lpOVFL=1 after the 9th, and drain yields 0x01..0x08 only.
REQ-037 Wrap and concurrency: prACK=1 continuously with 20 back-to-back pushes 0x10..0x23 -> output order is 0x10..0x23 and count never exceeds 1.
REQ-038 Full push+pop: at count 8, push 0xAA with prACK=1 in the same cycle -> count stays 8, lpOVFL=0, and 0xAA exits 8th after it.
REQ-039 Clear/reset: 5 bytes buffered, lpOVFL=1, then lpCLR pulse -> lpEMPTY=1, prVALID=0, lpOVFL=0 next cycle; repeat with an asynchronous rst mid-cycle -> same state immediately.
REQ-040 Parity (macro defined): prDATA=0x00 -> prPAR=1; prDATA=0x01 -> prPAR=0; macro undefined -> prPAR=0 always.
